// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared encodings and widths for the ID-stage branch redirect logic
package branch_pkg;

    localparam int PC_W  = 32;
    localparam int IDX_W = 26;
    localparam int OFF_W = 16;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLEZ = 3'b010,
        BR_BGTZ = 3'b011,
        BR_BLTZ = 3'b100,
        BR_BGEZ = 3'b101,
        BR_J    = 3'b110,
        BR_RSVD = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_REDIR = 2'b10
    } br_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational branch/jump target from PC and instruction index field
module branch_target_calc
    import branch_pkg::*;
(
    input  logic [PC_W-1:0]  pc_id,
    input  logic [IDX_W-1:0] instr_idx,
    input  logic             is_jump,
    output logic [PC_W-1:0]  target
);

    logic [PC_W-1:0]  pc_plus4;
    logic [OFF_W-1:0] off;
    logic [PC_W-1:0]  off_ext;

    always_comb begin
        pc_plus4 = pc_id + 32'd4;
        off      = instr_idx[OFF_W-1:0];
        off_ext  = {{14{off[OFF_W-1]}}, off, 2'b00};
        if (is_jump) begin
            target = {pc_plus4[31:28], instr_idx, 2'b00};
        end else begin
            target = pc_plus4 + off_ext;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - qualifies the comparator decision, stalls on pending operands, issues PC redirect
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic             cmp_out,
    input  logic             opnd_ready,
    input  logic [PC_W-1:0]  pc_id,
    input  logic [IDX_W-1:0] instr_idx,
    output logic             stall,
    output logic             redirect,
    output logic [PC_W-1:0]  target_pc,
    output logic             flush_if,
    output logic             br_done,
    output logic             ds_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e        state_q, state_d;
    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic             flush_q, flush_d;
    logic             done_q, done_d;
    logic             ds_err_q, ds_err_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             stall_c;
    logic             resolve;
    logic             taken;
    logic             is_jump;
    logic [PC_W-1:0]  target_c;

    assign is_jump = (br_type == BR_J);
    // Reserved encoding (111) falls outside both terms, so it is never taken.
    assign taken   = is_jump | ((br_type <= BR_BGEZ) & cmp_out);

    branch_target_calc u_target (
        .pc_id     (pc_id),
        .instr_idx (instr_idx),
        .is_jump   (is_jump),
        .target    (target_c)
    );

    always_comb begin
        state_d     = state_q;
        redirect_d  = 1'b0;
        target_d    = target_q;
        flush_d     = 1'b0;
        done_d      = 1'b0;
        ds_err_d    = 1'b0;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        stall_c     = 1'b0;
        resolve     = 1'b0;

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (br_valid) begin
                    if (opnd_ready) begin
                        resolve = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIR: begin
                state_d  = S_IDLE;
                ds_err_d = (DELAY_SLOT != 0) && br_valid;
            end
            default: state_d = S_IDLE;
        endcase

        if (resolve) begin
            done_d   = 1'b1;
            br_cnt_d = br_cnt_q + 1'b1;
            state_d  = S_IDLE;
            if (taken) begin
                redirect_d  = 1'b1;
                target_d    = target_c;
                flush_d     = (DELAY_SLOT == 0);
                taken_cnt_d = taken_cnt_q + 1'b1;
                state_d     = S_REDIR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            redirect_q  <= 1'b0;
            target_q    <= '0;
            flush_q     <= 1'b0;
            done_q      <= 1'b0;
            ds_err_q    <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            redirect_q  <= redirect_d;
            target_q    <= target_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            ds_err_q    <= ds_err_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign stall     = stall_c & reset;
    assign redirect  = redirect_q;
    assign target_pc = target_q;
    assign flush_if  = flush_q;
    assign br_done   = done_q;
    assign ds_err    = ds_err_q;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
ID-stage consumer of the branch comparator's 1-bit `out` decision in the pipelined MIPS core. It qualifies the decision against operand readiness, stalls while forwarded operands are pending, and computes the branch/jump target. It issues a registered one-cycle PC redirect (plus IF flush when no delay slot) and keeps branch and taken-branch counters for debug.

Parameters:
DELAY_SLOT, 1, 1 = MIPS delay slot executes (no IF flush); 0 = flush IF on redirect
CNT_W, 16, width of branch/taken counters (wrap-around)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
br_valid  in  1  branch/jump instruction present in ID this cycle
br_type  in  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez, 110 j, 111 reserved (never taken); same encoding as the comparator's s input
cmp_out  in  1  comparator result for br_type, from the comparator
opnd_ready  in  1  both comparator operands valid (forwarding resolved)
pc_id  in  32  PC of the ID instruction
instr_idx  in  26  instr[25:0]; [15:0] is the branch offset
stall  out  1  combinational; freeze PC/IF/ID
redirect  out  1  registered one-cycle pulse; PC mux selects target_pc
target_pc  out  32  registered redirect target, valid when redirect==1
flush_if  out  1  registered; squash IF/ID register, coincident with redirect
br_done  out  1  registered pulse; one branch resolved, taken or not
ds_err  out  1  registered pulse; branch seen in delay slot, ignored
br_cnt  out  CNT_W  resolved branches
taken_cnt  out  CNT_W  taken branches

Behaviour:
- Reset (reset==0 at posedge, any state): state=IDLE. redirect, target_pc, flush_if, br_done, ds_err and both counters go to 0. stall is forced to 0 while reset==0.
- taken = (br_type==110) | (br_type<=101 & cmp_out). Reserved 111 resolves as not-taken.
- Branch target = pc_id + 4 + {{14{off[15]}}, off, 2'b00}, 32-bit wrap. Jump target = {(pc_id+4)[31:28], instr_idx, 2'b00}.
- States: IDLE, WAIT, REDIR.
- IDLE:
  - br_valid & !opnd_ready: stall=1, next WAIT.
  - br_valid & opnd_ready: resolve this cycle, stall=0. Next edge: br_done=1, br_cnt+1.
  - If taken on that resolve: also next edge redirect=1, target_pc=target, flush_if=!DELAY_SLOT, taken_cnt+1, next REDIR. Otherwise stay IDLE.
- WAIT:
  - stall = br_valid & !opnd_ready.
  - opnd_ready & br_valid: resolve exactly as in IDLE.
  - br_valid drops (flushed by a later stage): return to IDLE with no count, no pulse.
  - No timeout.
- REDIR: lasts exactly one cycle (redirect/flush_if high), stall=0, next IDLE.
  - br_valid here is ignored: no resolve, no count.
  - If DELAY_SLOT==1 and br_valid, ds_err pulses next cycle.
- Latency: decision cycle N (operands ready) -> redirect/br_done in cycle N+1. Back-to-back branches are resolved at most every 2 cycles when taken, every cycle when not taken.
- All pulses deassert after one cycle unless re-triggered. Counters wrap at 2^CNT_W, independently.

Decomposition:
- Package branch_pkg holds:
  - br_type encodings (BR_BEQ..BR_J, BR_RSVD);
  - state encoding (S_IDLE, S_WAIT, S_REDIR);
  - width constants.
- One combinational sub-module, branch_target_calc: pc_id, instr_idx, is_jump -> target. It is reusable by the later jal/jr work.

Test Plan:
- Reset: reset=0 for 2 cycles mid-REDIR -> all outputs 0 next edge, state IDLE, counters 0.
- beq taken, forward offset:
  - Stimulus: br_valid=1, br_type=000, cmp_out=1, opnd_ready=1, pc_id=0x0040_0010, off=0x0003.
  - Next cycle: redirect=1, target_pc=0x0040_0020, br_done=1, flush_if=0 (DELAY_SLOT=1), br_cnt=1, taken_cnt=1.
- bne backward offset, DELAY_SLOT=0:
  - Stimulus: pc_id=0x0040_0010, off=0xFFFF, cmp_out=1.
  - Required: target_pc=0x0040_0010, flush_if=1 with redirect.
- Jump: br_type=110, cmp_out=0, pc_id=0x0040_0010, instr_idx=0x010_0000 -> redirect=1, target_pc=0x0040_0000.
- Operand stall:
  - Stimulus: br_valid=1, opnd_ready=0 for 3 cycles, then 1, with cmp_out=0 (blez).
  - Required: stall=1 for those 3 cycles; then br_done=1, redirect=0, br_cnt=1, taken_cnt=0.
- Delay-slot branch and wrap:
  - Branch in REDIR with DELAY_SLOT=1 -> ds_err=1, no count.
  - Separately, with CNT_W=4, 16 resolved branches -> br_cnt wraps to 0.
